subtree_rr_arbiter: RTL and testbench
=====================================

Name: subtree_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource among the N child instances of a hierarchy node. The default of 5 matches the node fan-out.
- Each child raises a request. The arbiter issues a registered one-hot grant. The owner keeps the grant until it drops its request or exceeds its hold budget.
- Sits at the parent node, between the child instances and the shared resource.

Parameters:
- N_REQ, 5, number of requesting child instances (2..16).
- MAX_HOLD, 16, maximum consecutive grant cycles per owner before forced rotation (>=1).
- ID_W, $clog2(N_REQ), width of the grant index.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-child request, level.
- gnt  output  N_REQ  one-hot grant, registered.
- gnt_valid  output  1  any grant active (OR of gnt).
- gnt_id  output  ID_W  index of the current owner; 0 when idle.
- preempt  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Reset (async assert): gnt=0, gnt_valid=0, gnt_id=0, preempt=0, state=IDLE, last-owner pointer=N_REQ-1 (so child 0 wins first), hold counter=0. Deassertion is synchronous to clk in the usual way.
- States:
  - IDLE: no grant.
  - OWN: grant held.
  - GAP: one dead cycle after any grant ends, so there is never back-to-back ownership change without a bubble.
- IDLE -> OWN: if any req at edge t, gnt asserts at t+1 for the first requester scanning from (last+1) mod N_REQ upward with wrap. The pointer is updated to the winner and the hold counter loads 1.
- OWN, owner req still high and hold<MAX_HOLD: stay; hold increments (saturating at MAX_HOLD).
- OWN, owner req low: -> GAP; gnt clears at the next edge; preempt=0.
- OWN, owner req high and hold==MAX_HOLD: -> GAP; gnt clears; preempt pulses for exactly that cycle.
- GAP -> IDLE if no req; otherwise -> OWN using the same rotate search, so the revoked owner is searched last.
- Non-owner requests never affect the current grant.
- Only one gnt bit is ever high. gnt_id is consistent with gnt in the same cycle.
- A single persistent requester with others idle is granted MAX_HOLD cycles, then one GAP cycle, then re-granted.
- Reset mid-grant: all outputs drop asynchronously; after release, arbitration restarts from child 0.
- req bits at indices >= N_REQ do not exist. An X on a non-owner req must not corrupt the state (assertion in the bench).

Optional Feature:
- Macro: SUBTREE_ARB_HOLD_LIMIT_EN.
- Defined: MAX_HOLD enforcement and the preempt pulse operate as above.
- Undefined:
  - The hold counter and preempt logic are not built; preempt is tied to 0.
  - An owner keeps the grant until it drops req.
  - All other behaviour, including the GAP cycle and rotation, is unchanged.

Test Plan:
- Reset then req=5'b00000 for 10 cycles -> gnt=0, gnt_valid=0, gnt_id=0 throughout.
- req=5'b10101 from cycle 0, each owner drops req 3 cycles after its grant -> grant order 0,2,4,0 with one GAP cycle between each; gnt_id sequence 0,2,4,0.
- Hold limit on, MAX_HOLD=16, req=5'b00010 held constant -> gnt=5'b00010 for 16 cycles, preempt=1 on the revoke edge, 1 GAP cycle, re-grant to 1.
- Hold limit on, req=5'b00011 constant, owner 0 -> after 16 cycles preempt, then gnt moves to child 1 (not child 0).
- Assert rst asynchronously mid-grant to child 3 -> gnt drops without a clock edge; after release with req=5'b01001 the first grant goes to child 0.
- Macro undefined, req=5'b00001 held 40 cycles -> gnt stays 5'b00001 for all 40, preempt never asserts.

Source files
------------

// File: rtl/subtree_rr_arbiter.sv
// Round-robin arbiter for the N_REQ children of a hierarchy node: registered one-hot grant,
// one dead GAP cycle between owners. Define SUBTREE_ARB_HOLD_LIMIT_EN to cap ownership at MAX_HOLD.
module subtree_rr_arbiter #(
  parameter int unsigned N_REQ    = 5,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned ID_W     = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_id,
  output logic             preempt
);

  typedef enum logic [1:0] {StIdle, StOwn, StGap} state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic             any_req;
  logic             owner_req;
  logic             hold_hit;
  logic [ID_W-1:0]  win_id;
  logic             win_found;
  int unsigned      cand;

`ifdef SUBTREE_ARB_HOLD_LIMIT_EN
  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

  logic [HoldW-1:0] hold_q, hold_d;
  logic             preempt_q, preempt_d;

  assign hold_hit = (hold_q == HoldW'(MAX_HOLD));
  assign preempt  = preempt_q;
`else
  assign hold_hit = 1'b0;
  assign preempt  = 1'b0;
`endif

  assign any_req   = |req;
  // last_q always holds the current owner while in StOwn
  assign owner_req = req[last_q];

  // Scan from the child after the last owner, wrapping, so the last owner is searched last
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    cand      = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (int'(last_q) + k) % N_REQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = ID_W'(cand);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StGap: state_d = win_found ? StOwn : StIdle;
      StOwn:         if (!owner_req || hold_hit) state_d = StGap;
      default:       state_d = StIdle;
    endcase
  end

  always_comb begin
    gnt_d  = '0;
    id_d   = '0;
    last_d = last_q;
`ifdef SUBTREE_ARB_HOLD_LIMIT_EN
    hold_d    = hold_q;
    preempt_d = 1'b0;
`endif
    unique case (state_q)
      StIdle, StGap: begin
        if (win_found) begin
          gnt_d  = {{(N_REQ-1){1'b0}}, 1'b1} << win_id;
          id_d   = win_id;
          last_d = win_id;
`ifdef SUBTREE_ARB_HOLD_LIMIT_EN
          hold_d = HoldW'(1);
`endif
        end
      end
      StOwn: begin
        if (state_d == StOwn) begin
          gnt_d = gnt_q;
          id_d  = id_q;
`ifdef SUBTREE_ARB_HOLD_LIMIT_EN
          if (!hold_hit) hold_d = hold_q + 1'b1;
`endif
        end else begin
`ifdef SUBTREE_ARB_HOLD_LIMIT_EN
          preempt_d = owner_req & hold_hit;
          hold_d    = '0;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q  <= '0;
      id_q   <= '0;
      last_q <= ID_W'(N_REQ - 1);
    end else begin
      gnt_q  <= gnt_d;
      id_q   <= id_d;
      last_q <= last_d;
    end
  end

`ifdef SUBTREE_ARB_HOLD_LIMIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end
`endif

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign gnt_id    = id_q;

endmodule

// File: tb/tb_subtree_rr_arbiter.sv
// Randomized scoreboard bench for subtree_rr_arbiter; the model tracks owner / hold time directly.
module tb_subtree_rr_arbiter;

  localparam int N        = 5;
  localparam int MAX_HOLD = 16;
  localparam int ID_W     = $clog2(N);
`ifdef SUBTREE_ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  typedef struct {
    logic [N-1:0] gnt;
    int           id;
    bit           pre;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic            gnt_valid;
  logic [ID_W-1:0] gnt_id;
  logic            preempt;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Model: who owns the resource, who owned it last, how long the owner has held it
  int m_owner;
  int m_last;
  int m_held;

  subtree_rr_arbiter #(
    .N_REQ   (N),
    .MAX_HOLD(MAX_HOLD),
    .ID_W    (ID_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id),
    .preempt  (preempt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input bit ok, input int act, input int want);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  // Model update on every edge; the expected outputs for the next cycle go to the scoreboard
  initial begin
    m_owner = -1;
    m_last  = N - 1;
    m_held  = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_owner = -1;
        m_last  = N - 1;
        m_held  = 0;
        exp_q.delete();
      end else begin
        exp_t e;
        e.pre = 1'b0;
        if (m_owner >= 0) begin
          if (!req[m_owner]) begin
            m_owner = -1;
          end else if (HOLD_EN && m_held >= MAX_HOLD) begin
            m_owner = -1;
            e.pre   = 1'b1;
          end else begin
            m_held++;
          end
        end else if (req != '0) begin
          for (int k = 1; k <= N; k++) begin
            if (m_owner < 0 && req[(m_last + k) % N]) m_owner = (m_last + k) % N;
          end
          m_last = m_owner;
          m_held = 1;
        end
        e.gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        e.id  = (m_owner >= 0) ? m_owner : 0;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation
  initial begin
    forever begin
      @(negedge clk);
      assert ($onehot0(gnt));
      if (!rst && exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        tests++;
        if (gnt !== e.gnt || gnt_valid !== (e.gnt != '0) || gnt_id !== ID_W'(e.id) ||
            preempt !== e.pre) begin
          fails++;
          $display("FAIL grant t=%0t: got gnt=%b valid=%b id=%0d pre=%b, want gnt=%b valid=%b id=%0d pre=%b",
                   $time, gnt, gnt_valid, gnt_id, preempt, e.gnt, (e.gnt != '0), e.id, e.pre);
        end
      end
    end
  end

  task automatic hold_req(input logic [N-1:0] r, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      req = r;
    end
  endtask

  initial begin
    logic [N-1:0] r;
    rst = 1'b1;
    req = '0;
    repeat (3) @(negedge clk);
    check("reset gnt", gnt === '0, int'(gnt), 0);
    check("reset valid", gnt_valid === 1'b0, int'(gnt_valid), 0);
    check("reset id", gnt_id === '0, int'(gnt_id), 0);
    check("reset preempt", preempt === 1'b0, int'(preempt), 0);
    rst = 1'b0;

    hold_req(5'b00000, 10);
    hold_req(5'b00010, 45);
    hold_req(5'b00000, 3);
    hold_req(5'b00011, 45);
    hold_req(5'b00000, 3);
    hold_req(5'b00001, 45);
    hold_req(5'b10101, 20);

    r = '0;
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      end
      if ($urandom_range(0, 63) == 0) r = '0;
      @(negedge clk);
      req = r;
    end

    // Asynchronous reset while child 3 owns the grant
    hold_req(5'b01000, 4);
    @(posedge clk);
    #1;
    check("owner before reset", gnt === 5'b01000, int'(gnt), 8);
    #1;
    rst = 1'b1;
    #1;
    check("async gnt", gnt === '0, int'(gnt), 0);
    check("async valid", gnt_valid === 1'b0, int'(gnt_valid), 0);
    check("async id", gnt_id === '0, int'(gnt_id), 0);
    @(negedge clk);
    req = 5'b01001;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("first after reset", gnt === 5'b00001, int'(gnt), 1);
    hold_req(5'b01001, 30);
    hold_req(5'b00000, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
